// File: rtl/stretch_pkg.sv
// Shared types and constants for the pulse stretcher: FSM encodings and timer width.
package stretch_pkg;

    localparam int unsigned TIMER_W = 16;
    localparam int unsigned PEND_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ON   = 2'b01,
        ST_GAP  = 2'b10
    } state_e;

endpackage

// File: rtl/pulse_stretcher_if.sv
// Trigger request and status outputs of the pulse stretcher.
interface pulse_stretcher_if;
    import stretch_pkg::*;

    logic              trigger;
    logic              led;
    logic              busy;
    logic [PEND_W-1:0] pending;
    logic              overflow;

    modport master (output trigger, input led, input busy, input pending, input overflow);
    modport slave  (input trigger, output led, output busy, output pending, output overflow);
endinterface

// File: rtl/stretch_timer.sv
// Phase down-counter: load has priority, counts down while enabled, holds at zero.
module stretch_timer
    import stretch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               en,
    output logic               zero_c
);

    logic [TIMER_W-1:0] count_q;
    logic [TIMER_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_c = (count_q == '0);

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle triggers into fixed LED pulses separated by a mandatory gap,
// queueing up to QUEUE_MAX triggers that arrive while a pulse or gap is in progress.
module pulse_stretcher
    import stretch_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = 40000,
    parameter int unsigned OFF_CYCLES = 20000,
    parameter int unsigned QUEUE_MAX  = 3
) (
    input  logic            clk5,
    input  logic            reset,
    pulse_stretcher_if.slave bus
);

    localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
    localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0]  Q_MAX    = PEND_W'(QUEUE_MAX);

    state_e             state_q, state_d;
    logic [PEND_W-1:0]  pending_q, pending_d;
    logic               overflow_q, overflow_d;
    logic               led_q, led_d;
    logic               busy_q, busy_d;

    logic               tmr_load;
    logic [TIMER_W-1:0] tmr_val;
    logic               tmr_en;
    logic               tmr_zero_c;

    logic               has_pend_c;
    logic               q_full_c;

    assign has_pend_c = (pending_q != '0);
    assign q_full_c   = (pending_q == Q_MAX);

    stretch_timer u_timer (
        .clk      (clk5),
        .rst_n    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .zero_c   (tmr_zero_c)
    );

    // Next state, queue bookkeeping and timer control
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        overflow_d = overflow_q;
        tmr_load   = 1'b0;
        tmr_val    = ON_LOAD;
        tmr_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.trigger || has_pend_c) begin
                    state_d  = ST_ON;
                    tmr_load = 1'b1;
                    if (has_pend_c && !bus.trigger) begin
                        pending_d = pending_q - PEND_W'(1);
                    end
                end
            end

            ST_ON: begin
                tmr_en = 1'b1;
                if (tmr_zero_c) begin
                    state_d  = ST_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = OFF_LOAD;
                end
                if (bus.trigger) begin
                    if (q_full_c) begin
                        overflow_d = 1'b1;
                    end else begin
                        pending_d = pending_q + PEND_W'(1);
                    end
                end
            end

            ST_GAP: begin
                tmr_en = 1'b1;
                if (tmr_zero_c) begin
                    // A trigger on the last gap cycle is serviced in place of a queued one
                    if (has_pend_c || bus.trigger) begin
                        state_d  = ST_ON;
                        tmr_load = 1'b1;
                        if (has_pend_c && !bus.trigger) begin
                            pending_d = pending_q - PEND_W'(1);
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (bus.trigger) begin
                    if (q_full_c) begin
                        overflow_d = 1'b1;
                    end else begin
                        pending_d = pending_q + PEND_W'(1);
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        led_d  = (state_d == ST_ON);
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk5 or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            led_q      <= led_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.led      = led_q;
    assign bus.busy     = busy_q;
    assign bus.pending  = pending_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed, table-driven bench for pulse_stretcher with ON=4, OFF=2, QUEUE_MAX=3.
module tb_pulse_stretcher;

    logic clk5;
    logic reset;

    pulse_stretcher_if bus ();

    pulse_stretcher #(
        .ON_CYCLES  (4),
        .OFF_CYCLES (2),
        .QUEUE_MAX  (3)
    ) dut (
        .clk5  (clk5),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk5 = 1'b0;
    always #5 clk5 = ~clk5;

    // Expected {led, busy, pending[1:0], overflow} held over cycles lo..hi
    typedef struct {
        int         lo;
        int         hi;
        logic [4:0] exp;
    } seg_t;

    seg_t tbl[$];
    int   n_checks;
    int   n_errors;

    function automatic logic [4:0] mk(input logic led, input logic busy,
                                      input logic [1:0] pend, input logic ovf);
        return {led, busy, pend, ovf};
    endfunction

    function automatic void add(input int lo, input int hi, input logic [4:0] exp);
        seg_t s;
        s.lo  = lo;
        s.hi  = hi;
        s.exp = exp;
        tbl.push_back(s);
    endfunction

    task automatic check(input string name, input logic [4:0] exp);
        logic [4:0] act;
        act = {bus.led, bus.busy, bus.pending, bus.overflow};
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: led/busy/pend/ovf got %b required %b", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk5);
        #1;
    endtask

    // Leaves the bench 1 time unit after the first edge following reset release (cycle 0)
    task automatic do_reset(input string name);
        reset       = 1'b0;
        bus.trigger = 1'b0;
        repeat (2) @(posedge clk5);
        #1;
        check({name, "_rst"}, 5'b0);
        @(negedge clk5);
        reset = 1'b1;
        step();
    endtask

    // Cycle c = interval after edge c; outputs checked there, trigger driven for edge c+1
    task automatic run_seq(input string name, input logic [63:0] trig, input int last);
        for (int c = 0; c <= last; c++) begin
            logic [4:0] e;
            logic       found;
            found = 1'b0;
            e     = '0;
            foreach (tbl[i]) begin
                if (c >= tbl[i].lo && c <= tbl[i].hi) begin
                    e     = tbl[i].exp;
                    found = 1'b1;
                end
            end
            if (found) check($sformatf("%s@%0d", name, c), e);
            bus.trigger = trig[c];
            step();
        end
        bus.trigger = 1'b0;
    endtask

    initial begin
        logic [63:0] trig;
        n_checks    = 0;
        n_errors    = 0;
        reset       = 1'b0;
        bus.trigger = 1'b0;

        // Single trigger
        do_reset("single");
        tbl.delete();
        add(0, 10, mk(0, 0, 2'd0, 0));
        add(11, 14, mk(1, 1, 2'd0, 0));
        add(15, 16, mk(0, 1, 2'd0, 0));
        add(17, 20, mk(0, 0, 2'd0, 0));
        trig = '0; trig[10] = 1'b1;
        run_seq("single", trig, 20);

        // Second trigger queued during ON
        do_reset("queue1");
        tbl.delete();
        add(0, 10, mk(0, 0, 2'd0, 0));
        add(11, 12, mk(1, 1, 2'd0, 0));
        add(13, 14, mk(1, 1, 2'd1, 0));
        add(15, 16, mk(0, 1, 2'd1, 0));
        add(17, 20, mk(1, 1, 2'd0, 0));
        add(21, 22, mk(0, 1, 2'd0, 0));
        add(23, 25, mk(0, 0, 2'd0, 0));
        trig = '0; trig[10] = 1'b1; trig[12] = 1'b1;
        run_seq("queue1", trig, 25);

        // Held trigger: saturation at QUEUE_MAX and sticky overflow
        do_reset("sat");
        tbl.delete();
        add(0, 10, mk(0, 0, 2'd0, 0));
        add(11, 11, mk(1, 1, 2'd0, 0));
        add(12, 12, mk(1, 1, 2'd1, 0));
        add(13, 13, mk(1, 1, 2'd2, 0));
        add(14, 14, mk(1, 1, 2'd3, 0));
        add(15, 16, mk(0, 1, 2'd3, 1));
        add(17, 20, mk(1, 1, 2'd2, 1));
        add(21, 22, mk(0, 1, 2'd2, 1));
        add(23, 26, mk(1, 1, 2'd1, 1));
        add(27, 28, mk(0, 1, 2'd1, 1));
        add(29, 32, mk(1, 1, 2'd0, 1));
        add(33, 34, mk(0, 1, 2'd0, 1));
        add(35, 38, mk(0, 0, 2'd0, 1));
        trig = '0;
        for (int i = 10; i <= 14; i++) trig[i] = 1'b1;
        run_seq("sat", trig, 38);

        // Trigger on last gap cycle goes straight back to ON
        do_reset("lastgap");
        tbl.delete();
        add(0, 10, mk(0, 0, 2'd0, 0));
        add(11, 14, mk(1, 1, 2'd0, 0));
        add(15, 16, mk(0, 1, 2'd0, 0));
        add(17, 20, mk(1, 1, 2'd0, 0));
        add(21, 22, mk(0, 1, 2'd0, 0));
        add(23, 25, mk(0, 0, 2'd0, 0));
        trig = '0; trig[10] = 1'b1; trig[16] = 1'b1;
        run_seq("lastgap", trig, 25);

        // Last-gap trigger with a queued entry: pending unchanged
        do_reset("lastgap_q");
        tbl.delete();
        add(0, 10, mk(0, 0, 2'd0, 0));
        add(11, 11, mk(1, 1, 2'd0, 0));
        add(12, 14, mk(1, 1, 2'd1, 0));
        add(15, 16, mk(0, 1, 2'd1, 0));
        add(17, 20, mk(1, 1, 2'd1, 0));
        add(21, 22, mk(0, 1, 2'd1, 0));
        add(23, 26, mk(1, 1, 2'd0, 0));
        add(27, 28, mk(0, 1, 2'd0, 0));
        add(29, 30, mk(0, 0, 2'd0, 0));
        trig = '0; trig[10] = 1'b1; trig[11] = 1'b1; trig[16] = 1'b1;
        run_seq("lastgap_q", trig, 30);

        // Asynchronous reset mid-ON discards the queue
        do_reset("abort");
        for (int c = 0; c <= 11; c++) begin
            bus.trigger = (c == 10 || c == 11);
            step();
        end
        bus.trigger = 1'b0;
        check("abort_pre", mk(1, 1, 2'd1, 0));
        reset = 1'b0;
        #1;
        check("abort_now", mk(0, 0, 2'd0, 0));
        repeat (6) @(posedge clk5);
        #1;
        check("abort_hold", mk(0, 0, 2'd0, 0));
        @(negedge clk5);
        reset = 1'b1;
        step();
        step();
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        for (int c = 21; c <= 24; c++) begin
            check($sformatf("abort_rel@%0d", c), mk(1, 1, 2'd0, 0));
            step();
        end
        check("abort_rel_gap", mk(0, 1, 2'd0, 0));

        // Trigger sampled on the very first edge after reset release
        reset       = 1'b0;
        bus.trigger = 1'b0;
        repeat (2) @(posedge clk5);
        @(negedge clk5);
        reset       = 1'b1;
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("first_edge_on%0d", c), mk(1, 1, 2'd0, 0));
            step();
        end
        check("first_edge_gap", mk(0, 1, 2'd0, 0));
        step();
        step();
        check("first_edge_idle", mk(0, 0, 2'd0, 0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
